vector_wb_stage: RTL and testbench

- Write-back stage directly downstream of the vector CPU IF/ID/EXE pipeline.
- Consumes EXE results: 4-lane vector r1..r4, write-enables, and WOM base address.
- Writes lanes back to the pixel and multiplier register files in one cycle.
- Serialises the 4 lanes into the single-port 32-bit write-out memory (WOM), back-pressuring EXE through `stall`.

---
 rtl/vector_wb_stage_pkg.sv | 16 +
 rtl/vector_wb_stage_if.sv | 104 ++++++++++
 rtl/vector_wb_stage_wom_serializer.sv | 95 +++++++++
 rtl/vector_wb_stage.sv | 93 +++++++++
 tb/tb_vector_wb_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/vector_wb_stage_pkg.sv
// Shared types for the vector CPU write-back stage.
// Lane/word sizes, vector bundle and WOM burst states.
package vector_cpu_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t [LANES-1:0] vec_t;

  typedef enum logic [0:0] {
    IDLE,
    BURST
  } wb_state_t;

endpackage

// File: rtl/vector_wb_stage_if.sv
// EXE-result, register-file and WOM bus bundle of the write-back stage.
// slave = write-back stage view, master = EXE/RF/WOM environment view.
interface vector_wb_stage_if #(
  parameter int ADDR_W = 16
);
  import vector_cpu_pkg::*;

  logic              in_valid;
  logic              stall;
  logic              wr_pxl;
  logic              wr_pos;
  logic              wr_mul_reg;
  logic              wr_mul_pos;
  logic              wr_wom;
  word_t             r1;
  word_t             r2;
  word_t             r3;
  word_t             r4;
  logic [31:0]       wom_addr;

  logic              we_pxl;
  logic              wr_pos_pxl;
  word_t             wdp1;
  word_t             wdp2;
  word_t             wdp3;
  word_t             wdp4;
  logic              we_mul;
  logic              wr_mul_pos_in;
  word_t             wdm1;
  word_t             wdm2;
  word_t             wdm3;
  word_t             wdm4;

  logic              wom_we;
  logic [ADDR_W-1:0] wom_waddr;
  word_t             wom_wdata;
  logic              wom_ready;
  logic              wom_busy;

  modport slave (
    input  in_valid,
    output stall,
    input  wr_pxl,
    input  wr_pos,
    input  wr_mul_reg,
    input  wr_mul_pos,
    input  wr_wom,
    input  r1,
    input  r2,
    input  r3,
    input  r4,
    input  wom_addr,
    output we_pxl,
    output wr_pos_pxl,
    output wdp1,
    output wdp2,
    output wdp3,
    output wdp4,
    output we_mul,
    output wr_mul_pos_in,
    output wdm1,
    output wdm2,
    output wdm3,
    output wdm4,
    output wom_we,
    output wom_waddr,
    output wom_wdata,
    input  wom_ready,
    output wom_busy
  );

  modport master (
    output in_valid,
    input  stall,
    output wr_pxl,
    output wr_pos,
    output wr_mul_reg,
    output wr_mul_pos,
    output wr_wom,
    output r1,
    output r2,
    output r3,
    output r4,
    output wom_addr,
    input  we_pxl,
    input  wr_pos_pxl,
    input  wdp1,
    input  wdp2,
    input  wdp3,
    input  wdp4,
    input  we_mul,
    input  wr_mul_pos_in,
    input  wdm1,
    input  wdm2,
    input  wdm3,
    input  wdm4,
    input  wom_we,
    input  wom_waddr,
    input  wom_wdata,
    output wom_ready,
    input  wom_busy
  );

endinterface

// File: rtl/vector_wb_stage_wom_serializer.sv
// Serialises one latched vector result into the single-port WOM,
// one lane per completed handshake, and produces the EXE stall term.
module wom_serializer
  import vector_cpu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int ADDR_STRIDE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  vec_t              i_data,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output word_t             o_wdata,
  output logic              o_busy,
  output logic              o_stall
);

  localparam int LW = $clog2(LANES);
  typedef logic [LW-1:0] lane_t;

  wb_state_t         r_state;
  wb_state_t         w_state_n;
  lane_t             r_lane;
  lane_t             w_lane_n;
  vec_t              r_buf;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_off;
  logic              w_last;
  logic              w_take;
  logic              w_busy;

  assign w_busy = (r_state == BURST);
  assign w_last = (r_lane == lane_t'(LANES - 1));

  always_comb begin
    w_state_n = r_state;
    w_lane_n  = r_lane;
    w_take    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_load) begin
          w_state_n = BURST;
          w_lane_n  = '0;
          w_take    = 1'b1;
        end
      end
      BURST: begin
        if (i_ready) begin
          if (w_last) begin
            // last lane retires; a new result may chain straight in
            if (i_load) begin
              w_lane_n = '0;
              w_take   = 1'b1;
            end else begin
              w_state_n = IDLE;
            end
          end else begin
            w_lane_n = r_lane + lane_t'(1);
          end
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lane  <= '0;
      r_buf   <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_n;
      r_lane  <= w_lane_n;
      if (w_take) begin
        r_buf  <= i_data;
        r_base <= i_base;
      end
    end
  end

  assign w_off   = ADDR_W'(r_lane) * ADDR_W'(ADDR_STRIDE);
  assign o_we    = w_busy;
  assign o_busy  = w_busy;
  assign o_waddr = w_busy ? (r_base + w_off) : '0;
  assign o_wdata = w_busy ? r_buf[r_lane] : '0;
  assign o_stall = w_busy && !(w_last && i_ready);

endmodule

// File: rtl/vector_wb_stage.sv
// Vector CPU write-back stage: registered pixel/multiplier RF
// write-back plus lane-serial store of results into the WOM.
module vector_wb_stage
  import vector_cpu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int ADDR_STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst,
  vector_wb_stage_if.slave wb
);

  vec_t              w_res;
  logic              w_accept;
  logic              w_stall;
  logic              w_load;

  logic              r_we_pxl;
  logic              r_pos_pxl;
  vec_t              r_wdp;
  logic              r_we_mul;
  logic              r_pos_mul;
  vec_t              r_wdm;

  logic              w_wom_we;
  logic [ADDR_W-1:0] w_wom_waddr;
  word_t             w_wom_wdata;
  logic              w_wom_busy;

  assign w_res    = {wb.r4, wb.r3, wb.r2, wb.r1};
  assign w_accept = wb.in_valid && !w_stall;
  assign w_load   = w_accept && wb.wr_wom;

  // enables pulse for one cycle; data holds until the next write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_pxl  <= 1'b0;
      r_pos_pxl <= 1'b0;
      r_wdp     <= '0;
      r_we_mul  <= 1'b0;
      r_pos_mul <= 1'b0;
      r_wdm     <= '0;
    end else begin
      r_we_pxl <= w_accept && wb.wr_pxl;
      r_we_mul <= w_accept && wb.wr_mul_reg;
      if (w_accept && wb.wr_pxl) begin
        r_pos_pxl <= wb.wr_pos;
        r_wdp     <= w_res;
      end
      if (w_accept && wb.wr_mul_reg) begin
        r_pos_mul <= wb.wr_mul_pos;
        r_wdm     <= w_res;
      end
    end
  end

  wom_serializer #(
    .ADDR_W      (ADDR_W),
    .ADDR_STRIDE (ADDR_STRIDE)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_res),
    .i_base  (wb.wom_addr[ADDR_W-1:0]),
    .i_ready (wb.wom_ready),
    .o_we    (w_wom_we),
    .o_waddr (w_wom_waddr),
    .o_wdata (w_wom_wdata),
    .o_busy  (w_wom_busy),
    .o_stall (w_stall)
  );

  assign wb.stall         = w_stall;
  assign wb.we_pxl        = r_we_pxl;
  assign wb.wr_pos_pxl    = r_pos_pxl;
  assign wb.wdp1          = r_wdp[0];
  assign wb.wdp2          = r_wdp[1];
  assign wb.wdp3          = r_wdp[2];
  assign wb.wdp4          = r_wdp[3];
  assign wb.we_mul        = r_we_mul;
  assign wb.wr_mul_pos_in = r_pos_mul;
  assign wb.wdm1          = r_wdm[0];
  assign wb.wdm2          = r_wdm[1];
  assign wb.wdm3          = r_wdm[2];
  assign wb.wdm4          = r_wdm[3];
  assign wb.wom_we        = w_wom_we;
  assign wb.wom_waddr     = w_wom_waddr;
  assign wb.wom_wdata     = w_wom_wdata;
  assign wb.wom_busy      = w_wom_busy;

endmodule

// File: tb/tb_vector_wb_stage.sv
// Bench for vector_wb_stage: directed cycle table, then random
// traffic against a queue-based model of the WOM write stream.
module tb_vector_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vector_wb_stage_if bus ();

  vector_wb_stage dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h", n, a, e);
  endtask

  typedef struct {
    logic        rs, v, px, ps, mu, mp, wo, rd;
    logic [31:0] ad;
    int          d;
    logic        es, ewp, eps, ewm, emp, ewe;
    logic [15:0] ea;
    int          ed, el;
    logic        ez;
  } row_t;

  function automatic row_t mk(
    logic rs, logic v, logic px, logic ps, logic mu, logic mp,
    logic wo, logic rd, logic [31:0] ad, int d,
    logic es, logic ewp, logic eps, logic ewm, logic emp, logic ewe,
    logic [15:0] ea, int ed, int el, logic ez);
    row_t r;
    r.rs = rs; r.v = v; r.px = px; r.ps = ps; r.mu = mu; r.mp = mp;
    r.wo = wo; r.rd = rd; r.ad = ad; r.d = d;
    r.es = es; r.ewp = ewp; r.eps = eps; r.ewm = ewm; r.emp = emp;
    r.ewe = ewe; r.ea = ea; r.ed = ed; r.el = el; r.ez = ez;
    return r;
  endfunction

  logic [31:0] ds [3][4];
  row_t        tbl [$];

  task automatic drive(logic rs, logic v, logic px, logic ps, logic mu,
                       logic mp, logic wo, logic rd, logic [31:0] ad,
                       logic [31:0] a, logic [31:0] b,
                       logic [31:0] c, logic [31:0] e);
    rst            = rs;
    bus.in_valid   = v;
    bus.wr_pxl     = px;
    bus.wr_pos     = ps;
    bus.wr_mul_reg = mu;
    bus.wr_mul_pos = mp;
    bus.wr_wom     = wo;
    bus.wom_ready  = rd;
    bus.wom_addr   = ad;
    bus.r1 = a; bus.r2 = b; bus.r3 = c; bus.r4 = e;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         q [$];
  logic        m_wep, m_pos, m_wem, m_mpos;
  logic [31:0] m_wdp [4];
  logic [31:0] m_wdm [4];

  initial begin
    ds[0] = '{32'h416D5367, 32'h416C5263, 32'h415D5267, 32'h426D506B};
    ds[1] = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    ds[2] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};

    // reset, pixel write-back, pixel+multiplier
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk(0,1,1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,1,1,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,1,0,0,0,0,1, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,1,0,1,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    // plain burst at 0x10
    tbl.push_back(mk(0,1,0,0,0,0,1,1,32'h10,2, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,0,0,0,0,1,16'h10,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,0,0,0,0,1,16'h11,2,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,0,0,0,0,1,16'h12,2,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,1,16'h13,2,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,0,0));
    // back-pressure at lane 1, with pixel write in parallel
    tbl.push_back(mk(0,1,1,0,0,0,1,1,32'h10,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,1,0,0,0,1,16'h10,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1,16'h11,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1,16'h11,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,0,0,0,0,1,16'h11,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,0,0,0,0,1,16'h12,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,1,16'h13,0,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,0,0));
    // back-to-back with address wrap
    tbl.push_back(mk(0,1,0,0,0,0,1,1,32'h20,1, 0,0,0,0,0,0,0,0,0,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,1,0,0,0,0,1,1,32'h0001FFFE,2,
                       (k != 3),0,0,0,0,1,16'(16'h20 + k),1,k,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,
                       (k != 3),0,0,0,0,1,16'(16'hFFFE + k),2,k,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,0,0));
    // reset at lane 2
    tbl.push_back(mk(0,1,0,0,0,0,1,1,32'h40,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,0,0,0,0,1,16'h40,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 1,0,0,0,0,1,16'h41,0,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0, 1,0,0,0,0,1,16'h42,0,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,0,1));

    drive(1,0,0,0,0,0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      row_t r;
      r = tbl[i];
      @(posedge clk);
      #1;
      drive(r.rs, r.v, r.px, r.ps, r.mu, r.mp, r.wo, r.rd, r.ad,
            ds[r.d][0], ds[r.d][1], ds[r.d][2], ds[r.d][3]);
      @(negedge clk);
      chk($sformatf("t%0d stall", i), bus.stall, r.es);
      chk($sformatf("t%0d we_pxl", i), bus.we_pxl, r.ewp);
      chk($sformatf("t%0d we_mul", i), bus.we_mul, r.ewm);
      chk($sformatf("t%0d wom_we", i), bus.wom_we, r.ewe);
      chk($sformatf("t%0d wom_busy", i), bus.wom_busy, r.ewe);
      if (r.ewp) begin
        chk($sformatf("t%0d pos_pxl", i), bus.wr_pos_pxl, r.eps);
        chk($sformatf("t%0d wdp1", i), bus.wdp1, ds[r.ed][0]);
        chk($sformatf("t%0d wdp2", i), bus.wdp2, ds[r.ed][1]);
        chk($sformatf("t%0d wdp3", i), bus.wdp3, ds[r.ed][2]);
        chk($sformatf("t%0d wdp4", i), bus.wdp4, ds[r.ed][3]);
      end
      if (r.ewm) begin
        chk($sformatf("t%0d pos_mul", i), bus.wr_mul_pos_in, r.emp);
        chk($sformatf("t%0d wdm1", i), bus.wdm1, ds[r.ed][0]);
        chk($sformatf("t%0d wdm4", i), bus.wdm4, ds[r.ed][3]);
      end
      if (r.ewe) begin
        chk($sformatf("t%0d waddr", i), bus.wom_waddr, r.ea);
        chk($sformatf("t%0d wdata", i), bus.wom_wdata, ds[r.ed][r.el]);
      end
      if (r.ez) begin
        chk($sformatf("t%0d zero_rf", i),
            bus.wdp1 | bus.wdp2 | bus.wdp3 | bus.wdp4 |
            bus.wdm1 | bus.wdm2 | bus.wdm3 | bus.wdm4, 0);
        chk($sformatf("t%0d zero_pos", i),
            {bus.wr_pos_pxl, bus.wr_mul_pos_in}, 0);
        chk($sformatf("t%0d zero_wom", i),
            bus.wom_wdata | 32'(bus.wom_waddr), 0);
      end
    end

    // random traffic; the model starts from the reset state
    @(posedge clk);
    #1;
    drive(1,0,0,0,0,0,0,0,0,0,0,0,0);
    @(posedge clk);
    q.delete();
    m_wep = 0; m_pos = 0; m_wem = 0; m_mpos = 0;
    m_wdp = '{0, 0, 0, 0};
    m_wdm = '{0, 0, 0, 0};

    for (int c = 0; c < 3000; c++) begin
      logic        rs, v, px, ps, mu, mp, wo, rd, es, acc;
      logic [31:0] ad;
      logic [31:0] rv [4];
      @(posedge clk);
      #1;
      rs = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 2) != 0);
      px = 1'($urandom); ps = 1'($urandom);
      mu = 1'($urandom); mp = 1'($urandom);
      wo = 1'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      ad = $urandom_range(0, 1) ? $urandom
         : {16'($urandom), 16'hFFFC | 16'($urandom_range(0, 3))};
      for (int k = 0; k < 4; k++) rv[k] = $urandom;
      drive(rs, v, px, ps, mu, mp, wo, rd, ad, rv[0], rv[1], rv[2], rv[3]);
      @(negedge clk);

      es = (q.size() > 0) && !(q.size() == 1 && rd);
      chk("r stall", bus.stall, es);
      chk("r wom_we", bus.wom_we, q.size() > 0);
      chk("r wom_busy", bus.wom_busy, q.size() > 0);
      if (q.size() > 0) begin
        chk("r waddr", bus.wom_waddr, q[0].a);
        chk("r wdata", bus.wom_wdata, q[0].d);
      end
      chk("r we_pxl", bus.we_pxl, m_wep);
      chk("r we_mul", bus.we_mul, m_wem);
      chk("r pos_pxl", bus.wr_pos_pxl, m_pos);
      chk("r pos_mul", bus.wr_mul_pos_in, m_mpos);
      chk("r wdp1", bus.wdp1, m_wdp[0]);
      chk("r wdp3", bus.wdp3, m_wdp[2]);
      chk("r wdm2", bus.wdm2, m_wdm[1]);
      chk("r wdm4", bus.wdm4, m_wdm[3]);

      if (rs) begin
        q.delete();
        m_wep = 0; m_pos = 0; m_wem = 0; m_mpos = 0;
        m_wdp = '{0, 0, 0, 0};
        m_wdm = '{0, 0, 0, 0};
      end else begin
        acc = v && !es;
        if (q.size() > 0 && rd) void'(q.pop_front());
        m_wep = acc && px;
        m_wem = acc && mu;
        if (m_wep) begin m_pos = ps; m_wdp = rv; end
        if (m_wem) begin m_mpos = mp; m_wdm = rv; end
        if (acc && wo)
          for (int k = 0; k < 4; k++)
            q.push_back('{a: 16'(ad[15:0] + 16'(k)), d: rv[k]});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
